// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage controller between execute and writeback.
// Turns a load/store request into one valid/ready memory transaction. It
// drives byte enables and lane-replicated store data, holds `stall` while the
// access is outstanding, and returns a sign- or zero-extended load result.
// Optional feature: define LSU_TIMEOUT_EN to build a REQ watchdog. The
// watchdog aborts the access with `err` after TIMEOUT cycles without mem_ready.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       readdata,
  output logic              done,
  output logic              err,
  output logic              stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A non-positive TIMEOUT would make the watchdog fire before any REQ cycle.
  // Only positive values are supported.
  if (TIMEOUT < 1) begin : g_timeout_must_be_positive
  end

  logic [1:0]        state;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic [1:0]        offset_q;
  logic [2:0]        funct3_q;
  logic [31:0]       readdata_q;
  logic              err_q;

  logic              access;
  logic              illegal;
  logic [3:0]        be_next;
  logic [31:0]       wdata_next;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_fmt;
  logic              timed_out;

  assign access = memread | memwrite;

  // Classify the incoming request. Only IDLE consults the result.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    illegal = memread & memwrite;
    case (funct3)
      F3_B, F3_BU: illegal = illegal;
      F3_H, F3_HU: if (addr[0]) illegal = 1'b1;
      F3_W:        if (addr[1:0] != 2'b00) illegal = 1'b1;
      default:     illegal = 1'b1;
    endcase
  end

  // Byte enables and replicated store data for the addressed lane(s).
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      default: be_next = 4'b1111;
    endcase
  end

  // Lane selection uses the offset registered at request time. The live
  // address may already belong to the next instruction.
  assign rd_byte = mem_rdata[{offset_q, 3'b000} +: 8];
  assign rd_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Extend the selected lane according to the registered funct3.
  always_comb begin
    load_fmt = mem_rdata;
    case (funct3_q)
      F3_B:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_fmt = {24'h0, rd_byte};
      F3_H:    load_fmt = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_fmt = {16'h0, rd_half};
      default: load_fmt = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Count REQ cycles without mem_ready. The count is held at zero in IDLE so
  // every REQ entry starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE) begin
      wait_cnt <= '0;
    end else if (state == S_REQ && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  // Main controller: accept in IDLE, hold the request in REQ, pulse in DONE.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then sees pre-edge values, whatever order the statements are written in.
    if (!rst) begin
      state       <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      offset_q    <= 2'b00;
      funct3_q    <= 3'b000;
      readdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            if (illegal) begin
              state      <= S_DONE;
              err_q      <= 1'b1;
              readdata_q <= '0;
            end else begin
              state       <= S_REQ;
              err_q       <= 1'b0;
              mem_we_q    <= memwrite;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= wdata_next;
              mem_be_q    <= be_next;
              offset_q    <= addr[1:0];
              funct3_q    <= funct3;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            readdata_q <= mem_we_q ? 32'h0 : load_fmt;
            state      <= S_DONE;
          end else if (timed_out) begin
            // An aborted store counts as not performed.
            readdata_q <= '0;
            err_q      <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (state == S_REQ);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) & err_q;
  assign stall     = ((state == S_IDLE) & access) | (state == S_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign readdata  = readdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven checks of load_store_unit plus hand-written
// multi-cycle sequences (reset in REQ, timeout or its absence). Expected
// results go into a scoreboard queue when a request is driven. They are
// popped when the unit pulses done.
module tb_load_store_unit;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        memread   = 1'b0;
  logic        memwrite  = 1'b0;
  logic [2:0]  funct3    = 3'b000;
  logic [31:0] addr      = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] readdata;
  logic        done;
  logic        err;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .readdata  (readdata),
    .done      (done),
    .err       (err),
    .stall     (stall)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;      // REQ cycles with mem_ready low before ready
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] exp_rd;
    logic        exp_err;
  } exp_t;

  vec_t vecs[15];
  vec_t sw8;
  exp_t sb_q[$];

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  task automatic sb_pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.scoreboard: got done with empty queue, expected a pending entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".readdata"}, readdata, e.exp_rd);
    check({tag, ".err"}, 32'(err), 32'(e.exp_err));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    stall_cycles;
    int    req_cycles;
    bit    seen_done;
    bit    stable_ok;
    string tag;
    tag          = $sformatf("vec%0d", idx);
    stall_cycles = 0;
    req_cycles   = 0;
    seen_done    = 1'b0;
    stable_ok    = 1'b1;
    @(posedge clk); #1;
    memread   = v.rd;
    memwrite  = v.wr;
    funct3    = v.f3;
    addr      = v.addr;
    wdata     = v.wdata;
    mem_ready = 1'b0;
    sb_q.push_back('{exp_rd: v.exp_rd, exp_err: v.exp_err});
    #1;
    check({tag, ".stall_idle"}, 32'(stall), 32'd1);
    if (stall) stall_cycles++;
    for (int cyc = 1; cyc < 64 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      if (stall) stall_cycles++;
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          check({tag, ".mem_addr"}, mem_addr, v.exp_addr);
          check({tag, ".mem_be"}, 32'(mem_be), 32'(v.exp_be));
          check({tag, ".mem_we"}, 32'(mem_we), 32'(v.exp_we));
          if (v.exp_we) check({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
        end else if (mem_addr !== v.exp_addr || mem_be !== v.exp_be || mem_we !== v.exp_we ||
                     (v.exp_we && mem_wdata !== v.exp_wdata)) begin
          stable_ok = 1'b0;
        end
        mem_ready = (req_cycles > v.delay);
        mem_rdata = mem_ready ? v.rdata : ~v.rdata;
      end else begin
        mem_ready = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        sb_pop_compare(tag);
        check({tag, ".stall_cycles"}, stall_cycles, v.exp_err ? 32'd1 : 32'(v.delay + 2));
        check({tag, ".req_cycles"}, req_cycles, v.exp_err ? 32'd0 : 32'(v.delay + 1));
        check({tag, ".req_stable"}, 32'(stable_ok), 32'd1);
      end
      if (cyc == 1) begin
        // The unit must ignore anything presented after IDLE.
        memread  = 1'b0;
        memwrite = 1'b0;
        funct3   = 3'b111;
        addr     = 32'hFFFF_FFFF;
        wdata    = 32'h5555_5555;
      end
    end
    if (!seen_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.done_timeout: got no done in 64 cycles, expected a done pulse", tag);
    end
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, {30'h0, done, err}, 32'h0);
    check({tag, ".readdata_hold"}, readdata, v.exp_rd);
    // A stray mem_ready in IDLE must not disturb anything.
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check({tag, ".idle_ready_ignored"}, {readdata[31:2], readdata[1:0] ^ {done, mem_req}},
          v.exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_done;
    bit got_done;
    int req_cnt;

    //            rd wr f3      addr          wdata         rdata         dly err we exp_addr      be       exp_wdata     exp_rd
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'h80FF_1234, 0, 1'b0, 1'b0, 32'h10,  4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0022, 32'h0,        32'hBEEF_0000, 3, 1'b0, 1'b0, 32'h20,  4'b1100, 32'h0,        32'h0000_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h1111_1111, 0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_F600, 0, 1'b0, 1'b0, 32'h0,   4'b0010, 32'h0,        32'h0000_00F6};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'h0,        1, 1'b0, 1'b1, 32'h40,  4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0104, 32'h0,        32'h0000_8001, 0, 1'b0, 1'b0, 32'h104, 4'b0011, 32'h0,        32'hFFFF_8001};
    vecs[6]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h2222_2222, 0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0208, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'h208, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h3333_3333, 0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0007, 32'h0000_00A5, 32'h0,        0, 1'b0, 1'b1, 32'h4,   4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_000C, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 1'b1, 32'hC,   4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0043, 32'h1234_5678, 32'h0,        0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0,        32'h007F_0000, 0, 1'b0, 1'b0, 32'h0,   4'b0100, 32'h0,        32'h0000_007F};
    vecs[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0006, 32'h0,        32'h7FFF_1234, 1, 1'b0, 1'b0, 32'h4,   4'b1100, 32'h0,        32'h0000_7FFF};
    vecs[14] = '{1'b0, 1'b1, 3'b110, 32'h0000_0000, 32'h9999_9999, 32'h0,        0, 1'b1, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0};
    sw8      = '{1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'h1122_3344, 32'h0,        0, 1'b0, 1'b1, 32'h8,   4'b1111, 32'h1122_3344, 32'h0};

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("reset.ctrl", {27'h0, mem_req, mem_we, done, err, stall}, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
    check("reset.mem_be", 32'(mem_be), 32'h0);
    check("reset.readdata", readdata, 32'h0);
    #9 rst = 1'b1;
    @(posedge clk); #1;
    check("idle.no_request", {30'h0, stall, mem_req}, 32'h0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset while a load waits in REQ
    @(posedge clk); #1;
    memread   = 1'b1;
    memwrite  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0040;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    memread = 1'b0;
    check("rst_req.req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_req.req_dropped", 32'(mem_req), 32'd0);
    check("rst_req.stall_dropped", 32'(stall), 32'd0);
    check("rst_req.readdata", readdata, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    #2 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("rst_req.no_done", 32'(saw_done), 32'd0);
    run_vec(sw8, 100);
    run_vec(vecs[7], 101);

    // Store with mem_ready held low
    @(posedge clk); #1;
    memwrite  = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_0010;
    wdata     = 32'h1234_5678;
    mem_ready = 1'b0;
    req_cnt   = 0;
    got_done  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    sb_q.push_back('{exp_rd: 32'h0, exp_err: 1'b1});
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(posedge clk); #1;
      memwrite = 1'b0;
      if (mem_req) req_cnt++;
      if (done) begin
        got_done = 1'b1;
        sb_pop_compare("timeout");
      end
    end
    check("timeout.done_seen", 32'(got_done), 32'd1);
    check("timeout.req_cycles", req_cnt, 32'd4);
`else
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      memwrite = 1'b0;
      if (mem_req) req_cnt++;
      if (done) got_done = 1'b1;
    end
    check("no_timeout.req_cycles", req_cnt, 32'd120);
    check("no_timeout.no_done", 32'(got_done), 32'd0);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
`endif

    check("scoreboard.leftover", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
